cajero_controlador: RTL and testbench
=====================================

# cajero_controlador

ATM transaction controller: the device under test that responds to the stimulus bench's card, PIN-digit, amount and balance signals. It accepts a 4-digit PIN serially and allows three attempts per card, with a warning after the second failure and a lock after the third. With a valid PIN it performs a deposit or a withdrawal against `balance_inicial` and reports the new balance. It sits between the keypad/card front-end and the account store.

## Interface
- `ANCHO_MONTO`, 32, width of the `monto` input.
- `ANCHO_BALANCE`, 64, width of the balance buses.
- `MAX_INTENTOS`, 3, failed PIN attempts that trigger a lock.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `tarjeta_recibida`  in  1  card present (level).
- `tipo_trans`  in  1  transaction type: 0 = deposit, 1 = withdrawal; sampled together with `monto_stb`.
- `digito_stb`  in  1  PIN digit strobe; may stay high for several cycles.
- `digito`  in  4  PIN digit value, 0–9.
- `pin_correcto`  in  16  expected PIN, first digit in [15:12].
- `monto_stb`  in  1  amount strobe.
- `monto`  in  ANCHO_MONTO  transaction amount, unsigned.
- `balance_inicial`  in  ANCHO_BALANCE  account balance, unsigned.
- `balance_stb`  out  1  one-cycle pulse: `balance_actualizado` is valid.
- `balance_actualizado`  out  ANCHO_BALANCE  resulting balance.
- `entregar_dinero`  out  1  dispense cash; held until the card is removed.
- `pin_incorrecto`  out  1  one-cycle pulse for each wrong PIN.
- `advertencia`  out  1  high after the (MAX_INTENTOS−1)th failure.
- `bloqueo`  out  1  locked; cleared only by `reset`.
- `fondos_insuficientes`  out  1  withdrawal refused; held until the card is removed.

## Operation
- **Strobe acceptance:** a strobe counts only on its rising edge: the input is 1 this cycle and was 0 in the previous sampled cycle. Holding a strobe high never yields a second digit.
- **States:** ESPERA_TARJETA, INGRESO_PIN, VERIFICA_PIN, ESPERA_MONTO, PROCESA, FIN, BLOQUEO.
- **ESPERA_TARJETA:** when `tarjeta_recibida`=1, move to INGRESO_PIN. Clear the digit counter, the PIN shift register and the attempt counter.
- **INGRESO_PIN:**
  - On each accepted digit: `pin_reg <= {pin_reg[11:0], digito}` and increment the counter.
  - After the 4th digit, move to VERIFICA_PIN.
- **VERIFICA_PIN, match:** clear attempts, drop `advertencia`, move to ESPERA_MONTO.
- **VERIFICA_PIN, mismatch:**
  - Increment attempts, pulse `pin_incorrecto`, clear the digit counter.
  - attempts = MAX_INTENTOS−1: set `advertencia`.
  - attempts = MAX_INTENTOS: set `bloqueo` and move to BLOQUEO; otherwise return to INGRESO_PIN.
- **ESPERA_MONTO:** on an accepted `monto_stb`, latch `monto`, `tipo_trans` and `balance_inicial`, then move to PROCESA.
- **PROCESA, deposit:** `balance_actualizado` = balance + zero-extended monto, modulo 2^ANCHO_BALANCE. Pulse `balance_stb`.
- **PROCESA, withdrawal with monto ≤ balance:** `balance_actualizado` = balance − monto. Pulse `balance_stb` and set `entregar_dinero`.
- **PROCESA, withdrawal with monto > balance:** set `fondos_insuficientes`. No `balance_stb`; `balance_actualizado` is unchanged.
- **After PROCESA:** move to FIN.
- **FIN:** when `tarjeta_recibida`=0, clear `entregar_dinero`, `fondos_insuficientes` and `advertencia`, then move to ESPERA_TARJETA.
- **Card removed mid-transaction:** in INGRESO_PIN, VERIFICA_PIN or ESPERA_MONTO, go to ESPERA_TARJETA. Partial PIN, attempts and `advertencia` are discarded. Every new card starts with 0 attempts.
- **BLOQUEO:** absorbing state. All inputs, including card removal, are ignored until `reset`.
- **`balance_actualizado`:** holds its last value between transactions; cleared only by `reset`.

## Timing
- **Reset:** all outputs 0, state ESPERA_TARJETA, all counters and registers 0. `reset` has priority over every other event on the same edge.
- **Card detection:** the first edge with `tarjeta_recibida`=1 enters INGRESO_PIN. A digit strobe on that same edge is ignored.
- **PIN result:** the 4th digit is accepted at edge E. VERIFICA_PIN occupies E+1. `pin_incorrecto`, `advertencia` and `bloqueo` are registered at E+1 and visible in the following cycle. `pin_incorrecto` is high for exactly one cycle.
- **Transaction result:** `monto_stb` is accepted at edge M. Results are registered at M+1. `balance_stb` is high for one cycle, and `balance_actualizado` is stable from that cycle on.
- **Strobes in the wrong state:** `digito_stb` outside INGRESO_PIN and `monto_stb` outside ESPERA_MONTO are ignored. Their edge-detect history still updates every cycle.
- **Comparison:** unsigned and full-width; a withdrawal with monto = balance succeeds, giving 0.

## Structure
- **Package `cajero_pkg`:** state enum `estado_t`, `PIN_DIGITOS`=4, default `MAX_INTENTOS`.
- **Sub-module `detector_flanco`:** one-cycle rising-edge detector, instantiated for `digito_stb` and `monto_stb`.
- **Synthesis constraint:** the FSM and the arithmetic remain in `cajero_controlador`.

## Test plan
- **Deposit:** PIN 3972 correct, `tipo_trans`=0, balance 100, monto 250 -> `balance_actualizado`=350, one `balance_stb` pulse, `entregar_dinero`=0.
- **Valid withdrawal:** `tipo_trans`=1, balance 100, monto 25 -> 75, `entregar_dinero`=1 until card removal.
- **Insufficient funds:** balance 100, monto 125 -> `fondos_insuficientes`=1, no `balance_stb`, `balance_actualizado` keeps its prior value. The next card withdraws 250 from 500 -> 250.
- **Lock:** three wrong PINs (3002, 3970, 3272) -> three `pin_incorrecto` pulses, `advertencia` after the 2nd, `bloqueo` after the 3rd. Further digits and card removal are ignored; `reset` clears everything.
- **Recovery after failures:** 3982 twice, then 3972 -> `advertencia` set then cleared. Withdraw 50 from 100 -> 50. The next card has 1 failure then correct 1234, withdraws 500 from 2500 -> 2000, and `advertencia` is never set.
- **Abort:** card removed after 2 digits -> ESPERA_TARJETA. The next card needs all 4 digits. A `digito_stb` held 3 cycles counts as one digit.

Source files
------------

// File: rtl/cajero_pkg.sv
// -----------------------------------------------------------------------------
// cajero_pkg
// Shared types and constants for the ATM transaction controller.
//   estado_t         : controller FSM state encoding
//   PIN_DIGITOS      : number of digits in a PIN
//   PIN_BITS         : width of the PIN shift register (4 bits per digit)
//   MAX_INTENTOS_DEF : default number of failed attempts that locks the card
// -----------------------------------------------------------------------------
package cajero_pkg;

  localparam int PIN_DIGITOS      = 4;
  localparam int PIN_BITS         = PIN_DIGITOS * 4;
  localparam int MAX_INTENTOS_DEF = 3;

  typedef enum logic [2:0] {
    ESPERA_TARJETA,
    INGRESO_PIN,
    VERIFICA_PIN,
    ESPERA_MONTO,
    PROCESA,
    FIN,
    BLOQUEO
  } estado_t;

endpackage : cajero_pkg

// File: rtl/detector_flanco.sv
// -----------------------------------------------------------------------------
// detector_flanco
// One-cycle rising-edge detector for keypad strobes. The output is high in the
// cycle where the input is 1 and was 0 on the previous clock edge, so a
// strobe held high for many cycles produces a single pulse.
// Ports:
//   clk       in  clock, rising edge
//   reset     in  synchronous active-high reset (history cleared to 0)
//   i_senal   in  raw strobe level
//   o_flanco  out rising-edge pulse (combinational from i_senal and history)
// -----------------------------------------------------------------------------
module detector_flanco (
  input  logic clk,
  input  logic reset,
  input  logic i_senal,
  output logic o_flanco
);

  logic r_previo;

  // History updates every cycle regardless of what the consumer is doing, so
  // a strobe that rises while the controller is busy is not seen later.
  // NOTE: sequential state is written with non-blocking assignments so every
  // register samples pre-edge values and simulation matches the hardware.
  always_ff @(posedge clk) begin
    if (reset) r_previo <= 1'b0;
    else       r_previo <= i_senal;
  end

  assign o_flanco = i_senal & ~r_previo;

endmodule : detector_flanco

// File: rtl/cajero_controlador.sv
// -----------------------------------------------------------------------------
// cajero_controlador
// ATM transaction controller. Accepts a serial 4-digit PIN with a limited
// number of attempts, then performs one deposit or withdrawal against the
// supplied account balance and reports the result.
// Ports:
//   clk                   in  clock, all state updates on rising edge
//   reset                 in  synchronous active-high reset
//   tarjeta_recibida      in  card present (level)
//   tipo_trans            in  0 = deposit, 1 = withdrawal (sampled with monto_stb)
//   digito_stb            in  PIN digit strobe (rising edge counts)
//   digito                in  PIN digit value 0-9
//   pin_correcto          in  expected PIN, first digit in the top nibble
//   monto_stb             in  amount strobe (rising edge counts)
//   monto                 in  transaction amount, unsigned
//   balance_inicial       in  account balance, unsigned
//   balance_stb           out one-cycle pulse: balance_actualizado valid
//   balance_actualizado   out resulting balance, held between transactions
//   entregar_dinero       out dispense cash, held until card removal
//   pin_incorrecto        out one-cycle pulse per wrong PIN
//   advertencia           out last attempt remaining
//   bloqueo               out card locked, cleared only by reset
//   fondos_insuficientes  out withdrawal refused, held until card removal
// -----------------------------------------------------------------------------
module cajero_controlador
  import cajero_pkg::*;
#(
  parameter int ANCHO_MONTO   = 32,
  parameter int ANCHO_BALANCE = 64,
  parameter int MAX_INTENTOS  = MAX_INTENTOS_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     tarjeta_recibida,
  input  logic                     tipo_trans,
  input  logic                     digito_stb,
  input  logic [3:0]               digito,
  input  logic [PIN_BITS-1:0]      pin_correcto,
  input  logic                     monto_stb,
  input  logic [ANCHO_MONTO-1:0]   monto,
  input  logic [ANCHO_BALANCE-1:0] balance_inicial,
  output logic                     balance_stb,
  output logic [ANCHO_BALANCE-1:0] balance_actualizado,
  output logic                     entregar_dinero,
  output logic                     pin_incorrecto,
  output logic                     advertencia,
  output logic                     bloqueo,
  output logic                     fondos_insuficientes
);

  localparam int ANCHO_INT = $clog2(MAX_INTENTOS + 1);
  localparam int ANCHO_CNT = $clog2(PIN_DIGITOS + 1);

  estado_t                  r_estado;
  logic [ANCHO_CNT-1:0]     r_cnt_digitos;
  logic [PIN_BITS-1:0]      r_pin;
  logic [ANCHO_INT-1:0]     r_intentos;
  logic [ANCHO_MONTO-1:0]   r_monto;
  logic                     r_tipo;
  logic [ANCHO_BALANCE-1:0] r_balance;

  logic                     w_digito_ok;
  logic                     w_monto_ok;
  logic [ANCHO_CNT-1:0]     w_cnt_sig;
  logic [ANCHO_INT-1:0]     w_intentos_sig;
  logic [ANCHO_BALANCE-1:0] w_monto_ext;
  logic [ANCHO_BALANCE-1:0] w_suma;
  logic [ANCHO_BALANCE-1:0] w_resta;
  logic                     w_fondos_ok;
  logic                     w_abortar;

  detector_flanco u_flanco_digito (
    .clk      (clk),
    .reset    (reset),
    .i_senal  (digito_stb),
    .o_flanco (w_digito_ok)
  );

  detector_flanco u_flanco_monto (
    .clk      (clk),
    .reset    (reset),
    .i_senal  (monto_stb),
    .o_flanco (w_monto_ok)
  );

  assign w_cnt_sig      = r_cnt_digitos + ANCHO_CNT'(1);
  assign w_intentos_sig = r_intentos + ANCHO_INT'(1);

  // Arithmetic on the latched operands; the deposit wraps modulo 2^ANCHO_BALANCE
  // and the funds check is a full-width unsigned compare (monto == balance is ok).
  assign w_monto_ext = ANCHO_BALANCE'(r_monto);
  assign w_suma      = r_balance + w_monto_ext;
  assign w_resta     = r_balance - w_monto_ext;
  assign w_fondos_ok = (w_monto_ext <= r_balance);

  // Pulling the card during PIN entry or amount selection discards the session.
  assign w_abortar = !tarjeta_recibida &&
                     (r_estado inside {INGRESO_PIN, VERIFICA_PIN, ESPERA_MONTO});

  always_ff @(posedge clk) begin
    if (reset) begin
      r_estado             <= ESPERA_TARJETA;
      r_cnt_digitos        <= '0;
      r_pin                <= '0;
      r_intentos           <= '0;
      r_monto              <= '0;
      r_tipo               <= 1'b0;
      r_balance            <= '0;
      balance_stb          <= 1'b0;
      balance_actualizado  <= '0;
      entregar_dinero      <= 1'b0;
      pin_incorrecto       <= 1'b0;
      advertencia          <= 1'b0;
      bloqueo              <= 1'b0;
      fondos_insuficientes <= 1'b0;
    end else begin
      // Pulse outputs default low; the states below raise them for one cycle.
      balance_stb    <= 1'b0;
      pin_incorrecto <= 1'b0;

      if (w_abortar) begin
        r_estado      <= ESPERA_TARJETA;
        r_cnt_digitos <= '0;
        r_pin         <= '0;
        r_intentos    <= '0;
        advertencia   <= 1'b0;
      end else begin
        case (r_estado)
          ESPERA_TARJETA: begin
            r_cnt_digitos <= '0;
            r_pin         <= '0;
            r_intentos    <= '0;
            if (tarjeta_recibida) r_estado <= INGRESO_PIN;
          end

          INGRESO_PIN: begin
            if (w_digito_ok) begin
              r_pin         <= {r_pin[PIN_BITS-5:0], digito};
              r_cnt_digitos <= w_cnt_sig;
              if (w_cnt_sig == ANCHO_CNT'(PIN_DIGITOS)) r_estado <= VERIFICA_PIN;
            end
          end

          VERIFICA_PIN: begin
            if (r_pin == pin_correcto) begin
              r_intentos  <= '0;
              advertencia <= 1'b0;
              r_estado    <= ESPERA_MONTO;
            end else begin
              r_intentos     <= w_intentos_sig;
              pin_incorrecto <= 1'b1;
              r_cnt_digitos  <= '0;
              if (w_intentos_sig == ANCHO_INT'(MAX_INTENTOS - 1)) advertencia <= 1'b1;
              if (w_intentos_sig == ANCHO_INT'(MAX_INTENTOS)) begin
                bloqueo  <= 1'b1;
                r_estado <= BLOQUEO;
              end else begin
                r_estado <= INGRESO_PIN;
              end
            end
          end

          ESPERA_MONTO: begin
            if (w_monto_ok) begin
              r_monto   <= monto;
              r_tipo    <= tipo_trans;
              r_balance <= balance_inicial;
              r_estado  <= PROCESA;
            end
          end

          PROCESA: begin
            if (!r_tipo) begin
              balance_actualizado <= w_suma;
              balance_stb         <= 1'b1;
            end else if (w_fondos_ok) begin
              balance_actualizado <= w_resta;
              balance_stb         <= 1'b1;
              entregar_dinero     <= 1'b1;
            end else begin
              fondos_insuficientes <= 1'b1;
            end
            r_estado <= FIN;
          end

          FIN: begin
            if (!tarjeta_recibida) begin
              entregar_dinero      <= 1'b0;
              fondos_insuficientes <= 1'b0;
              advertencia          <= 1'b0;
              r_estado             <= ESPERA_TARJETA;
            end
          end

          // Absorbing: only reset leaves this state.
          BLOQUEO: r_estado <= BLOQUEO;

          default: r_estado <= ESPERA_TARJETA;
        endcase
      end
    end
  end

endmodule : cajero_controlador

// File: tb/tb_cajero_controlador.sv
// -----------------------------------------------------------------------------
// tb_cajero_controlador
// Directed self-checking bench for the ATM transaction controller. Inputs are
// driven 1 time unit after each rising edge and outputs are sampled at the same
// point, i.e. after the edge's updates have settled.
// -----------------------------------------------------------------------------
module tb_cajero_controlador;

  logic        clk;
  logic        reset;
  logic        tarjeta_recibida;
  logic        tipo_trans;
  logic        digito_stb;
  logic [3:0]  digito;
  logic [15:0] pin_correcto;
  logic        monto_stb;
  logic [31:0] monto;
  logic [63:0] balance_inicial;
  logic        balance_stb;
  logic [63:0] balance_actualizado;
  logic        entregar_dinero;
  logic        pin_incorrecto;
  logic        advertencia;
  logic        bloqueo;
  logic        fondos_insuficientes;

  int n_vec = 0;
  int n_err = 0;

  cajero_controlador dut (
    .clk                  (clk),
    .reset                (reset),
    .tarjeta_recibida     (tarjeta_recibida),
    .tipo_trans           (tipo_trans),
    .digito_stb           (digito_stb),
    .digito               (digito),
    .pin_correcto         (pin_correcto),
    .monto_stb            (monto_stb),
    .monto                (monto),
    .balance_inicial      (balance_inicial),
    .balance_stb          (balance_stb),
    .balance_actualizado  (balance_actualizado),
    .entregar_dinero      (entregar_dinero),
    .pin_incorrecto       (pin_incorrecto),
    .advertencia          (advertencia),
    .bloqueo              (bloqueo),
    .fondos_insuficientes (fondos_insuficientes)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press_digit(input logic [3:0] d);
    digito     = d;
    digito_stb = 1'b1;
    tick();
    digito_stb = 1'b0;
    tick();
  endtask

  // Returns one cycle after the 4th digit's edge, when the PIN verdict is visible.
  task automatic enter_pin(input logic [15:0] p);
    for (int i = 0; i < 4; i++) press_digit(p[15-4*i -: 4]);
  endtask

  task automatic insert_card();
    tarjeta_recibida = 1'b1;
    tick();
  endtask

  task automatic remove_card();
    tarjeta_recibida = 1'b0;
    tick();
  endtask

  // Returns one cycle after the accepting edge, when the result is visible.
  task automatic transact(input logic tipo, input logic [31:0] m, input logic [63:0] b);
    tipo_trans      = tipo;
    monto           = m;
    balance_inicial = b;
    monto_stb       = 1'b1;
    tick();
    monto_stb = 1'b0;
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset            = 1'b1;
    tarjeta_recibida = 1'b0;
    tipo_trans       = 1'b0;
    digito_stb       = 1'b0;
    digito           = 4'd0;
    pin_correcto     = 16'h3972;
    monto_stb        = 1'b0;
    monto            = '0;
    balance_inicial  = '0;
    tick();
    tick();
    reset = 1'b0;
    tick();

    // Reset state
    check("rst_balance", balance_actualizado, 64'd0);
    check("rst_stb", balance_stb, 1'b0);
    check("rst_entregar", entregar_dinero, 1'b0);
    check("rst_pin_inc", pin_incorrecto, 1'b0);
    check("rst_adv", advertencia, 1'b0);
    check("rst_bloqueo", bloqueo, 1'b0);
    check("rst_fondos", fondos_insuficientes, 1'b0);

    // Deposit; a digit strobe on the card-detect edge must be ignored
    tarjeta_recibida = 1'b1;
    digito           = 4'd5;
    digito_stb       = 1'b1;
    tick();
    digito_stb = 1'b0;
    tick();
    enter_pin(16'h3972);
    check("dep_pin_ok", pin_incorrecto, 1'b0);
    transact(1'b0, 32'd250, 64'd100);
    check("dep_stb", balance_stb, 1'b1);
    check("dep_balance", balance_actualizado, 64'd350);
    check("dep_entregar", entregar_dinero, 1'b0);
    tick();
    check("dep_stb_one_cycle", balance_stb, 1'b0);
    check("dep_balance_hold", balance_actualizado, 64'd350);
    remove_card();

    // Valid withdrawal
    insert_card();
    enter_pin(16'h3972);
    transact(1'b1, 32'd25, 64'd100);
    check("wd_stb", balance_stb, 1'b1);
    check("wd_balance", balance_actualizado, 64'd75);
    check("wd_entregar", entregar_dinero, 1'b1);
    tick();
    tick();
    check("wd_entregar_held", entregar_dinero, 1'b1);
    remove_card();
    check("wd_entregar_clr", entregar_dinero, 1'b0);

    // Insufficient funds, then a good withdrawal on the next card
    insert_card();
    enter_pin(16'h3972);
    transact(1'b1, 32'd125, 64'd100);
    check("nsf_flag", fondos_insuficientes, 1'b1);
    check("nsf_no_stb", balance_stb, 1'b0);
    check("nsf_balance_kept", balance_actualizado, 64'd75);
    check("nsf_no_cash", entregar_dinero, 1'b0);
    remove_card();
    check("nsf_flag_clr", fondos_insuficientes, 1'b0);
    insert_card();
    enter_pin(16'h3972);
    transact(1'b1, 32'd250, 64'd500);
    check("nsf_next_balance", balance_actualizado, 64'd250);
    remove_card();

    // Recovery after two failures
    insert_card();
    enter_pin(16'h3982);
    check("rec_fail1_pulse", pin_incorrecto, 1'b1);
    check("rec_fail1_adv", advertencia, 1'b0);
    tick();
    check("rec_fail1_pulse_end", pin_incorrecto, 1'b0);
    enter_pin(16'h3982);
    check("rec_fail2_pulse", pin_incorrecto, 1'b1);
    check("rec_fail2_adv", advertencia, 1'b1);
    enter_pin(16'h3972);
    check("rec_ok_pulse", pin_incorrecto, 1'b0);
    check("rec_ok_adv_clr", advertencia, 1'b0);
    transact(1'b1, 32'd50, 64'd100);
    check("rec_balance", balance_actualizado, 64'd50);
    remove_card();

    // New card starts with zero attempts: one failure gives no warning
    pin_correcto = 16'h1234;
    insert_card();
    enter_pin(16'h1235);
    check("rec2_fail_pulse", pin_incorrecto, 1'b1);
    check("rec2_fail_adv", advertencia, 1'b0);
    enter_pin(16'h1234);
    check("rec2_ok_adv", advertencia, 1'b0);
    transact(1'b1, 32'd500, 64'd2500);
    check("rec2_balance", balance_actualizado, 64'd2000);
    check("rec2_adv_never", advertencia, 1'b0);
    remove_card();

    // Abort after two digits; held strobe; amount strobe during PIN entry
    pin_correcto = 16'h3972;
    insert_card();
    press_digit(4'd3);
    press_digit(4'd9);
    remove_card();
    insert_card();
    tipo_trans = 1'b0;
    monto_stb  = 1'b1;
    tick();
    monto_stb = 1'b0;
    tick();
    check("abort_monto_ignored", balance_stb, 1'b0);
    press_digit(4'd3);
    press_digit(4'd9);
    check("abort_partial_gone", pin_incorrecto, 1'b0);
    digito     = 4'd7;
    digito_stb = 1'b1;
    tick();
    tick();
    tick();
    digito_stb = 1'b0;
    tick();
    check("held_one_digit", pin_incorrecto, 1'b0);
    press_digit(4'd2);
    check("abort_pin_ok", pin_incorrecto, 1'b0);
    transact(1'b1, 32'd40, 64'd40);
    check("exact_wd_stb", balance_stb, 1'b1);
    check("exact_wd_balance", balance_actualizado, 64'd0);
    check("exact_wd_cash", entregar_dinero, 1'b1);
    remove_card();

    // Deposit wraps modulo 2^64
    insert_card();
    enter_pin(16'h3972);
    transact(1'b0, 32'd32, 64'hFFFF_FFFF_FFFF_FFF0);
    check("wrap_stb", balance_stb, 1'b1);
    check("wrap_balance", balance_actualizado, 64'd16);
    remove_card();

    // Lock after three failures
    insert_card();
    enter_pin(16'h3002);
    check("lock_f1_pulse", pin_incorrecto, 1'b1);
    check("lock_f1_adv", advertencia, 1'b0);
    check("lock_f1_blq", bloqueo, 1'b0);
    enter_pin(16'h3970);
    check("lock_f2_pulse", pin_incorrecto, 1'b1);
    check("lock_f2_adv", advertencia, 1'b1);
    check("lock_f2_blq", bloqueo, 1'b0);
    enter_pin(16'h3272);
    check("lock_f3_pulse", pin_incorrecto, 1'b1);
    check("lock_f3_blq", bloqueo, 1'b1);
    tick();
    check("lock_pulse_end", pin_incorrecto, 1'b0);
    enter_pin(16'h3972);
    remove_card();
    transact(1'b0, 32'd7, 64'd7);
    check("lock_held", bloqueo, 1'b1);
    check("lock_adv_held", advertencia, 1'b1);
    check("lock_no_stb", balance_stb, 1'b0);
    check("lock_balance_kept", balance_actualizado, 64'd16);
    check("lock_no_pin_pulse", pin_incorrecto, 1'b0);

    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    check("unlock_blq", bloqueo, 1'b0);
    check("unlock_adv", advertencia, 1'b0);
    check("unlock_balance", balance_actualizado, 64'd0);
    insert_card();
    enter_pin(16'h3972);
    check("post_rst_pin_ok", pin_incorrecto, 1'b0);
    transact(1'b0, 32'd5, 64'd10);
    check("post_rst_balance", balance_actualizado, 64'd15);
    remove_card();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_cajero_controlador
